// File: rtl/sdram_arbiter_if.sv
// Bundles the instruction-L1, data-L1 and SDRAM-controller buses around sdram_arbiter.
// The slave modport is the arbiter's view. The master modport is the caches' and controller's view.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_we;
    logic                  i_start;
    logic [DATA_WIDTH-1:0] i_q;
    logic                  i_done;

    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  d_we;
    logic                  d_start;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  d_done;

    logic [ADDR_WIDTH-1:0] sdc_addr;
    logic [DATA_WIDTH-1:0] sdc_data;
    logic                  sdc_we;
    logic                  sdc_start;
    logic [DATA_WIDTH-1:0] sdc_q;
    logic                  sdc_done;

    modport slave (
        input  i_addr, i_data, i_we, i_start,
        output i_q, i_done,
        input  d_addr, d_data, d_we, d_start,
        output d_q, d_done,
        output sdc_addr, sdc_data, sdc_we, sdc_start,
        input  sdc_q, sdc_done
    );

    modport master (
        output i_addr, i_data, i_we, i_start,
        input  i_q, i_done,
        output d_addr, d_data, d_we, d_start,
        input  d_q, d_done,
        input  sdc_addr, sdc_data, sdc_we, sdc_start,
        output sdc_q, sdc_done
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-master (I-L1 / D-L1) arbiter onto one SDRAM controller bus, with one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; by default the data L1 wins.
//
// state   | meaning
// IDLE    | no transaction; waiting for i_start / d_start
// GRANT_I | instruction L1 owns the controller, sdc_* latched
// GRANT_D | data L1 owns the controller, sdc_* latched
// RELEASE | done-pulse cycle; requester drops start, no new grant
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sdc_addr_q, sdc_addr_d;
    logic [DATA_WIDTH-1:0] sdc_data_q, sdc_data_d;
    logic                  sdc_we_q, sdc_we_d;
    logic                  sdc_start_q, sdc_start_d;
    logic [DATA_WIDTH-1:0] i_q_q, i_q_d;
    logic [DATA_WIDTH-1:0] d_q_q, d_q_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  win_is_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_grant_q, last_grant_d;   // 1 = data L1
`endif

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.i_start && bus.d_start) win_is_d = ~last_grant_q;
        else                            win_is_d = bus.d_start;
`else
        win_is_d = bus.d_start;
`endif
    end

    always_comb begin
        state_d     = state_q;
        sdc_addr_d  = sdc_addr_q;
        sdc_data_d  = sdc_data_q;
        sdc_we_d    = sdc_we_q;
        sdc_start_d = sdc_start_q;
        i_q_d       = i_q_q;
        d_q_d       = d_q_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_start || bus.d_start) begin
                    sdc_start_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = win_is_d;
`endif
                    if (win_is_d) begin
                        state_d    = GRANT_D;
                        sdc_addr_d = bus.d_addr;
                        sdc_data_d = bus.d_data;
                        sdc_we_d   = bus.d_we;
                    end else begin
                        state_d    = GRANT_I;
                        sdc_addr_d = bus.i_addr;
                        sdc_data_d = bus.i_data;
                        sdc_we_d   = bus.i_we;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                // Requester-side changes (including a dropped start) are ignored until the controller finishes.
                if (bus.sdc_done) begin
                    if (state_q == GRANT_I) begin
                        i_done_d = 1'b1;
                        if (!sdc_we_q) i_q_d = bus.sdc_q;
                    end else begin
                        d_done_d = 1'b1;
                        if (!sdc_we_q) d_q_d = bus.sdc_q;
                    end
                    sdc_start_d = 1'b0;
                    sdc_we_d    = 1'b0;
                    sdc_addr_d  = '0;
                    sdc_data_d  = '0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
            i_q_q       <= '0;
            d_q_q       <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdc_addr_q  <= sdc_addr_d;
            sdc_data_q  <= sdc_data_d;
            sdc_we_q    <= sdc_we_d;
            sdc_start_q <= sdc_start_d;
            i_q_q       <= i_q_d;
            d_q_q       <= d_q_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`endif

    assign bus.sdc_addr  = sdc_addr_q;
    assign bus.sdc_data  = sdc_data_q;
    assign bus.sdc_we    = sdc_we_q;
    assign bus.sdc_start = sdc_start_q;
    assign bus.i_q       = i_q_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_q       = d_q_q;
    assign bus.d_done    = d_done_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table of request vectors plus hand-written corner sequences.
// A queue holds the grants the bench expects, and a controller model consumes that queue and answers each grant.
module tb_sdram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          lat;
        bit          b2b;
    } txn_t;

    typedef struct {
        bit          i_req;
        bit          d_req;
        logic [31:0] i_addr;
        logic [31:0] i_data;
        bit          i_we;
        logic [31:0] d_addr;
        logic [31:0] d_data;
        bit          d_we;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        int          lat;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    txn_t        exp_q[$];
    txn_t        cur;
    bit          ctrl_busy = 0;
    int          ctrl_cnt = 0;
    int          done_stage = 0;
    logic [31:0] mq_i = '0;
    logic [31:0] mq_d = '0;
    bit          last_d = 1'b1;
    int          cyc = 0;
    int          last_done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One clock: check done pulses, run the controller model, let requesters drop start on their done.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!reset) return;
        if (done_stage == 1) begin
            if (!cur.we) begin
                if (cur.is_d) mq_d = cur.rdata;
                else          mq_i = cur.rdata;
            end
            chk("i_done pulse", {31'b0, bus.i_done}, {31'b0, !cur.is_d});
            chk("d_done pulse", {31'b0, bus.d_done}, {31'b0, cur.is_d});
            chk("i_q", bus.i_q, mq_i);
            chk("d_q", bus.d_q, mq_d);
            chk("sdc_start cleared", {31'b0, bus.sdc_start}, 32'd0);
            chk("sdc_we cleared", {31'b0, bus.sdc_we}, 32'd0);
            chk("sdc_addr cleared", bus.sdc_addr, 32'd0);
            chk("sdc_data cleared", bus.sdc_data, 32'd0);
            last_done_cyc = cyc;
            done_stage = 2;
        end else begin
            chk("i_done quiet", {31'b0, bus.i_done}, 32'd0);
            chk("d_done quiet", {31'b0, bus.d_done}, 32'd0);
            if (done_stage == 2) done_stage = 0;
        end
        if (bus.sdc_done) bus.sdc_done = 1'b0;
        if (ctrl_busy) begin
            ctrl_cnt++;
            chk("hold sdc_start", {31'b0, bus.sdc_start}, 32'd1);
            chk("hold sdc_addr", bus.sdc_addr, cur.addr);
            chk("hold sdc_data", bus.sdc_data, cur.data);
            chk("hold sdc_we", {31'b0, bus.sdc_we}, {31'b0, cur.we});
            if (ctrl_cnt == cur.lat) begin
                bus.sdc_done = 1'b1;
                bus.sdc_q    = cur.rdata;
                ctrl_busy    = 0;
                done_stage   = 1;
            end
        end else if (bus.sdc_start) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected grant");
            end else begin
                cur = exp_q.pop_front();
                chk("grant sdc_addr", bus.sdc_addr, cur.addr);
                chk("grant sdc_data", bus.sdc_data, cur.data);
                chk("grant sdc_we", {31'b0, bus.sdc_we}, {31'b0, cur.we});
                if (cur.b2b) chk("done-to-start spacing", cyc - last_done_cyc, 32'd2);
                ctrl_busy = 1;
                ctrl_cnt  = 0;
            end
        end
        if (bus.i_done) bus.i_start = 1'b0;
        if (bus.d_done) bus.d_start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((bus.i_start || bus.d_start || exp_q.size() != 0 || ctrl_busy || done_stage != 0)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            fail_now("timeout waiting for transactions to finish");
            exp_q.delete();
            ctrl_busy = 0;
            done_stage = 0;
        end
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!ctrl_busy && n < budget) begin
            tick();
            n++;
        end
        if (!ctrl_busy) fail_now("timeout waiting for grant");
    endtask

    task automatic apply_vec(input vec_t v);
        txn_t ti;
        txn_t td;
        bit   first_d;
        ti = '{is_d: 1'b0, we: v.i_we, addr: v.i_addr, data: v.i_data,
               rdata: v.i_rdata, lat: v.lat, b2b: 1'b0};
        td = '{is_d: 1'b1, we: v.d_we, addr: v.d_addr, data: v.d_data,
               rdata: v.d_rdata, lat: v.lat, b2b: 1'b0};
        bus.i_addr = v.i_addr;
        bus.i_data = v.i_data;
        bus.i_we   = v.i_we;
        bus.d_addr = v.d_addr;
        bus.d_data = v.d_data;
        bus.d_we   = v.d_we;
        if (v.i_req && v.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_d = !last_d;
`else
            first_d = 1'b1;
`endif
            if (first_d) begin
                ti.b2b = 1'b1;
                exp_q.push_back(td);
                exp_q.push_back(ti);
                last_d = 1'b0;
            end else begin
                td.b2b = 1'b1;
                exp_q.push_back(ti);
                exp_q.push_back(td);
                last_d = 1'b1;
            end
        end else if (v.d_req) begin
            exp_q.push_back(td);
            last_d = 1'b1;
        end else if (v.i_req) begin
            exp_q.push_back(ti);
            last_d = 1'b0;
        end
        bus.i_start = v.i_req;
        bus.d_start = v.d_req;
        run_until_idle(200);
    endtask

    vec_t vecs[8];
    txn_t t;

    initial begin
        vecs[0] = '{0, 1, 32'h0, 32'h0, 0, 32'h0000_0100, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 5};
        vecs[1] = '{1, 0, 32'h0000_0020, 32'h1234_5678, 1, 32'h0, 32'h0, 0, 32'hBAD0_BAD0, 32'h0, 3};
        vecs[2] = '{1, 0, 32'h0080_0004, 32'h0, 0, 32'h0, 32'h0, 0, 32'hCAFE_F00D, 32'h0, 1};
        vecs[3] = '{1, 1, 32'hFFFF_FFFC, 32'h0, 0, 32'h0000_0055, 32'hA5A5_A5A5, 1,
                    32'h1111_1111, 32'h9999_9999, 2};
        vecs[4] = '{0, 1, 32'h0, 32'h0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 32'h2222_2222, 4};
        vecs[5] = '{1, 1, 32'h0000_0300, 32'h0, 0, 32'h0000_0400, 32'h0, 0,
                    32'h3333_3333, 32'h4444_4444, 1};
        vecs[6] = '{1, 1, 32'h0000_0500, 32'h0, 0, 32'h0000_0600, 32'h0, 0,
                    32'h5555_5555, 32'h6666_6666, 3};
        vecs[7] = '{0, 1, 32'h0, 32'h0, 0, 32'h0000_0700, 32'hFEED_0001, 1, 32'h0, 32'h7777_7777, 2};

        reset = 1'b0;
        bus.i_addr = '0; bus.i_data = '0; bus.i_we = 1'b0; bus.i_start = 1'b0;
        bus.d_addr = '0; bus.d_data = '0; bus.d_we = 1'b0; bus.d_start = 1'b0;
        bus.sdc_q = '0;  bus.sdc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset sdc_start", {31'b0, bus.sdc_start}, 32'd0);
        chk("reset sdc_addr", bus.sdc_addr, 32'd0);
        chk("reset sdc_data", bus.sdc_data, 32'd0);
        chk("reset sdc_we", {31'b0, bus.sdc_we}, 32'd0);
        chk("reset i_q", bus.i_q, 32'd0);
        chk("reset d_q", bus.d_q, 32'd0);
        chk("reset i_done", {31'b0, bus.i_done}, 32'd0);
        chk("reset d_done", {31'b0, bus.d_done}, 32'd0);
        #2 reset = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) apply_vec(vecs[k]);

        // Requester address changes while granted: controller must keep seeing the latched request.
        t = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_0100, data: 32'h0, rdata: 32'hABCD_0001, lat: 6, b2b: 1'b0};
        bus.d_addr = 32'h0000_0100; bus.d_data = 32'h0; bus.d_we = 1'b0;
        exp_q.push_back(t);
        last_d = 1'b1;
        bus.d_start = 1'b1;
        wait_busy(20);
        bus.d_addr = 32'h0000_0999; bus.d_data = 32'h0BAD_0BAD; bus.d_we = 1'b1;
        run_until_idle(50);

        // Requester drops start two cycles after the grant: the transaction still completes once.
        t = '{is_d: 1'b1, we: 1'b0, addr: 32'h0000_0A00, data: 32'h0, rdata: 32'hABCD_0002, lat: 5, b2b: 1'b0};
        bus.d_addr = 32'h0000_0A00; bus.d_data = 32'h0; bus.d_we = 1'b0;
        exp_q.push_back(t);
        last_d = 1'b1;
        bus.d_start = 1'b1;
        wait_busy(20);
        tick();
        tick();
        bus.d_start = 1'b0;
        run_until_idle(50);

        // A stray sdc_done while idle is ignored.
        bus.sdc_q = 32'hFFFF_0000;
        bus.sdc_done = 1'b1;
        tick();
        tick();
        chk("stray done i_q", bus.i_q, mq_i);
        chk("stray done d_q", bus.d_q, mq_d);
        chk("stray done sdc_start", {31'b0, bus.sdc_start}, 32'd0);

        // Reset during a granted transaction drops sdc_start at once and discards the result.
        t = '{is_d: 1'b0, we: 1'b0, addr: 32'h0000_0040, data: 32'h0, rdata: 32'h7777_0000, lat: 8, b2b: 1'b0};
        bus.i_addr = 32'h0000_0040; bus.i_data = 32'h0; bus.i_we = 1'b0;
        exp_q.push_back(t);
        last_d = 1'b0;
        bus.i_start = 1'b1;
        wait_busy(20);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async reset sdc_start", {31'b0, bus.sdc_start}, 32'd0);
        chk("async reset i_q", bus.i_q, 32'd0);
        chk("async reset d_q", bus.d_q, 32'd0);
        bus.i_start = 1'b0;
        ctrl_busy = 0;
        done_stage = 0;
        exp_q.delete();
        mq_i = '0;
        mq_d = '0;
        last_d = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) tick();
        chk("post-reset sdc_start", {31'b0, bus.sdc_start}, 32'd0);
        chk("post-reset i_q", bus.i_q, 32'd0);
        apply_vec(vecs[5]);
        apply_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end
endmodule
